// File: rtl/register_display_scanner.sv
// register_display_scanner
//   Front-panel stage beside the register file. Chooses which register is
//   shown through the register file's debug read port and renders the
//   returned 32-bit word as 8 hex digits on active-low 7-segment outputs.
//   The select is stepped by two debounced push-buttons or by an auto-scan
//   timer, and it wraps within 0..31.
//
// Ports
//   clk             system clock, all state on the rising edge
//   rst_n           asynchronous active-low reset
//   btn_next        raw push-button (active-high, asynchronous, bouncy): select + 1
//   btn_prev        raw push-button (active-high, asynchronous, bouncy): select - 1
//   auto_en         level; 1 = step the select every AUTO_SCAN_CYCLES cycles
//   display_data    register contents for display_select (combinational read)
//   display_select  registered register index presented to the register file
//   hex_out         digit i = hex_out[7i+6:7i] shows nibble i of the data, gfedcba, active-low
module register_display_scanner #(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter int AUTO_SCAN_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        auto_en,
    input  logic [31:0] display_data,
    output logic [4:0]  display_select,
    output logic [55:0] hex_out
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES  > 1) ? $clog2(DEBOUNCE_CYCLES)  : 1;
    localparam int AUTO_W = (AUTO_SCAN_CYCLES > 1) ? $clog2(AUTO_SCAN_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_SCAN_CYCLES - 1);

    // Bit 0 is the "next" button, bit 1 the "prev" button.
    logic [1:0]             btn_raw;
    logic [1:0]             sync_a;
    logic [1:0]             sync_b;
    logic [1:0]             deb_level;
    logic [1:0][DEB_W-1:0]  deb_cnt;
    logic [1:0]             step_pulse;

    logic [AUTO_W-1:0]      auto_cnt;
    logic                   auto_tick;
    logic                   any_pulse;
    logic [4:0]             next_select;
    logic [31:0]            data_q;

    assign btn_raw = {btn_prev, btn_next};

    // Two-flop synchroniser followed by a debounce counter. The counter only
    // runs while the synchronised level disagrees with the accepted level, so
    // any bounce back to the accepted level restarts the qualification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a    <= '0;
            sync_b    <= '0;
            deb_level <= '0;
            deb_cnt   <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb_level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_level[i] <= sync_b[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The step pulse is the cycle in which the accepted level is about to
    // rise, so the select moves on the same edge that deb_level goes high.
    // A release (accepted level falling) never pulses.
    assign step_pulse[0] = sync_b[0] & ~deb_level[0] & (deb_cnt[0] == DEB_LAST);
    assign step_pulse[1] = sync_b[1] & ~deb_level[1] & (deb_cnt[1] == DEB_LAST);
    assign any_pulse     = |step_pulse;

    // Auto-scan interval. A manual step restarts the interval so the display
    // lingers a full period on a register the user just chose.
    assign auto_tick = auto_en && (auto_cnt == AUTO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!auto_en || any_pulse || auto_tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // Buttons take priority over the tick; both buttons together cancel out.
    always_comb begin
        next_select = display_select;
        case (step_pulse)
            2'b01:   next_select = display_select + 5'd1;
            2'b10:   next_select = display_select - 5'd1;
            2'b11:   next_select = display_select;
            default: begin
                if (auto_tick) begin
                    next_select = display_select + 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_select <= '0;
        end else begin
            display_select <= next_select;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Data is sampled every cycle (not only on select changes) so writes to
    // the displayed register show up live, two cycles after they happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            hex_out <= '1;
        end else begin
            data_q <= display_data;
            for (int i = 0; i < 8; i++) begin
                hex_out[7*i +: 7] <= seg7(data_q[4*i +: 4]);
            end
        end
    end

endmodule
